// File: rtl/fibcore_pkg.sv
// Shared fibcore types and widths: ALU opcodes, register/data widths, issue payload.
package fibcore_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 3;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctl;
    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  src_b;
    logic [REG_W-1:0] rd;
    logic             we;
  } issue_t;

  // Operand with x0 forced to zero and same-cycle writeback forwarding.
  function automatic logic [XLEN-1:0] operand_sel(
    input logic [REG_W-1:0] rs,
    input logic             wb_valid,
    input logic [REG_W-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data,
    input logic [XLEN-1:0]  rf_data
  );
    if (rs == '0) begin
      return '0;
    end else if (wb_valid && (wb_rd == rs)) begin
      return wb_data;
    end
    return rf_data;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to zero.
module reg_file
  import fibcore_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [REG_W-1:0] raddr_a_i,
  input  logic [REG_W-1:0] raddr_b_i,
  output logic [XLEN-1:0]  rdata_a_o,
  output logic [XLEN-1:0]  rdata_b_o,
  input  logic             we_i,
  input  logic [REG_W-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/operand_issue.sv
// fibcore issue stage: operand read with writeback bypass, busy scoreboard, one-entry output slot to the ALU.
module operand_issue
  import fibcore_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ALU_W-1:0] in_alu_ctl,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic             in_we,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_alu_ctl,
  output logic [XLEN-1:0]  out_src_a,
  output logic [XLEN-1:0]  out_src_b,
  output logic [REG_W-1:0] out_rd,
  output logic             out_we
);

  logic [NREG-1:0] busy_q, busy_d;
  issue_t          slot_q, slot_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] op_a, op_b;
  logic            rs1_ok, rs2_ok, waw, slot_free;

  reg_file u_reg_file (
    .clk       (clk),
    .rstn      (rstn),
    .raddr_a_i (in_rs1),
    .raddr_b_i (in_rs2),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (wb_valid),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data)
  );

  assign op_a = operand_sel(in_rs1, wb_valid, wb_rd, wb_data, rf_a);
  assign op_b = in_use_imm ? in_imm : operand_sel(in_rs2, wb_valid, wb_rd, wb_data, rf_b);

  // A pending source is still usable if its value arrives on the writeback port this cycle.
  assign rs1_ok = (in_rs1 == '0) || !busy_q[in_rs1] || (wb_valid && (wb_rd == in_rs1));
  assign rs2_ok = in_use_imm || (in_rs2 == '0) || !busy_q[in_rs2] ||
                  (wb_valid && (wb_rd == in_rs2));
  assign waw    = in_we && (in_rd != '0) && busy_q[in_rd] && !(wb_valid && (wb_rd == in_rd));

  assign slot_free = !valid_q || out_ready;
  assign in_ready  = in_valid && rs1_ok && rs2_ok && !waw && slot_free && !flush;

  // Slot and scoreboard update; an issue's busy set is applied last so it wins over clears.
  always_comb begin
    busy_d  = busy_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    if (wb_valid && (wb_rd != '0)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (flush) begin
      valid_d = 1'b0;
      if (valid_q && slot_q.we && (slot_q.rd != '0)) begin
        busy_d[slot_q.rd] = 1'b0;
      end
    end else if (in_ready) begin
      slot_d.alu_ctl = in_alu_ctl;
      slot_d.src_a   = op_a;
      slot_d.src_b   = op_b;
      slot_d.rd      = in_rd;
      slot_d.we      = in_we;
      valid_d        = 1'b1;
      if (in_we && (in_rd != '0)) begin
        busy_d[in_rd] = 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_ctl = slot_q.alu_ctl;
  assign out_src_a   = slot_q.src_a;
  assign out_src_b   = slot_q.src_b;
  assign out_rd      = slot_q.rd;
  assign out_we      = slot_q.we;

endmodule
